// File: rtl/pal_bus_pkg.sv
// Package: pal_bus_pkg
// Shared definitions for the palette CPU-port bus: palette address/data
// widths (also used by the DAR wrapper and the CPU-port mux) and the state
// encoding of the palette bus master FSM.
package pal_bus_pkg;

  localparam int PAL_ADDR_W = 14;
  localparam int PAL_DATA_W = 16;

  // Fixed encodings keep the state register readable in legacy debug dumps.
  typedef enum logic [2:0] {
    PBM_IDLE    = 3'd0,
    PBM_REQ     = 3'd1,
    PBM_SETUP   = 3'd2,
    PBM_STROBE  = 3'd3,
    PBM_RELEASE = 3'd4,
    PBM_OUTPUT  = 3'd5,
    PBM_FINISH  = 3'd6
  } pbm_state_t;

endpackage

// File: rtl/palette_bus_master.sv
// Module: palette_bus_master
// Bus initiator for the TC0260DAR palette CPU port. Streams palette words
// into the palette (write mode) or out of it (read mode) using 68k-style
// cycles (CS, RWn, UDSn/LDSn, DTACKn) on a bus shared with the CPU.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start/dir/base_addr/count  transfer command, sampled when idle
//   busy, done, timeout_err    transfer status (timeout_err is sticky)
//   in_data/in_valid/in_ready  write-mode word stream (valid/ready)
//   out_data/out_valid/out_ready  read-mode word stream (valid/ready)
//   bus_req/bus_gnt       palette bus arbitration
//   bus_cs, bus_addr, bus_wdata, bus_rdata, bus_rwn,
//   bus_udsn, bus_ldsn, bus_dtackn   DAR CPU-port cycle signals
module palette_bus_master
  import pal_bus_pkg::*;
#(
  parameter int ADDR_W        = PAL_ADDR_W,
  parameter int DATA_W        = PAL_DATA_W,
  parameter int STROBE_MIN    = 2,
  parameter int DTACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_cs,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rwn,
  output logic              bus_udsn,
  output logic              bus_ldsn,
  input  logic              bus_dtackn
);

  // One counter width covers both the strobe-length and the timeout counts.
  localparam int CNT_MAX = (STROBE_MIN > DTACK_TIMEOUT) ? STROBE_MIN : DTACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  STB_MIN_C = CNT_W'(STROBE_MIN);
  localparam logic [CNT_W-1:0]  TO_LAST_C = CNT_W'(DTACK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WCNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WCNT_ZERO = {(ADDR_W+1){1'b0}};

  pbm_state_t        state_q, state_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  stb_q, stb_d;   // strobe cycles so far, saturates at STROBE_MIN
  logic [CNT_W-1:0]  to_q, to_d;     // consecutive strobe cycles with DTACKn high
  logic              terr_q, terr_d;

  // Next-state and datapath update logic for the bus master FSM.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stb_d   = stb_q;
    to_d    = to_q;
    terr_d  = terr_q;

    case (state_q)
      PBM_IDLE: begin
        if (start) begin
          dir_d  = dir;
          addr_d = base_addr;
          wcnt_d = count;
          terr_d = 1'b0;
          if (count == WCNT_ZERO) begin
            state_d = PBM_FINISH;
          end else begin
            state_d = PBM_REQ;
          end
        end else begin
          state_d = PBM_IDLE;
        end
      end

      PBM_REQ: begin
        if (bus_gnt) begin
          state_d = PBM_SETUP;
        end else begin
          state_d = PBM_REQ;
        end
      end

      PBM_SETUP: begin
        // First STROBE cycle is counted as 1.
        stb_d = CNT_ONE;
        to_d  = CNT_ZERO;
        if (dir_q) begin
          state_d = PBM_STROBE;
        end else if (in_valid) begin
          wdata_d = in_data;
          state_d = PBM_STROBE;
        end else begin
          state_d = PBM_SETUP;
        end
      end

      PBM_STROBE: begin
        if (stb_q < STB_MIN_C) begin
          stb_d = stb_q + CNT_ONE;
        end else begin
          stb_d = stb_q;
        end
        if (!bus_dtackn) begin
          to_d = CNT_ZERO;
          if (stb_q >= STB_MIN_C) begin
            state_d = PBM_RELEASE;
            if (dir_q) begin
              rdata_d = bus_rdata;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            state_d = PBM_STROBE;
          end
        end else if (to_q == TO_LAST_C) begin
          // Abort: finish this cycle cleanly, then no further words.
          terr_d  = 1'b1;
          state_d = PBM_RELEASE;
        end else begin
          to_d    = to_q + CNT_ONE;
          state_d = PBM_STROBE;
        end
      end

      PBM_RELEASE: begin
        addr_d = addr_q + ADDR_ONE;
        wcnt_d = wcnt_q - WCNT_ONE;
        if (terr_q) begin
          state_d = PBM_FINISH;
        end else if (dir_q) begin
          state_d = PBM_OUTPUT;
        end else if (wcnt_q == WCNT_ONE) begin
          state_d = PBM_FINISH;
        end else if (bus_gnt) begin
          state_d = PBM_SETUP;
        end else begin
          state_d = PBM_REQ;
        end
      end

      PBM_OUTPUT: begin
        // Word count was already decremented in RELEASE.
        if (!out_ready) begin
          state_d = PBM_OUTPUT;
        end else if (wcnt_q == WCNT_ZERO) begin
          state_d = PBM_FINISH;
        end else if (bus_gnt) begin
          state_d = PBM_SETUP;
        end else begin
          state_d = PBM_REQ;
        end
      end

      PBM_FINISH: begin
        state_d = PBM_IDLE;
      end

      default: begin
        state_d = PBM_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PBM_IDLE;
      dir_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wcnt_q  <= WCNT_ZERO;
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      stb_q   <= CNT_ZERO;
      to_q    <= CNT_ZERO;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      stb_q   <= stb_d;
      to_q    <= to_d;
      terr_q  <= terr_d;
    end
  end

  // Bus and status outputs decode straight from registered state.
  assign bus_req     = (state_q != PBM_IDLE) && (state_q != PBM_FINISH);
  assign bus_cs      = (state_q == PBM_SETUP) || (state_q == PBM_STROBE);
  assign bus_rwn     = bus_cs ? dir_q : 1'b1;
  assign bus_udsn    = (state_q != PBM_STROBE);
  assign bus_ldsn    = (state_q != PBM_STROBE);
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign busy        = (state_q != PBM_IDLE);
  assign done        = (state_q == PBM_FINISH);
  assign timeout_err = terr_q;
  // Ready is only raised in the accepting cycle, so it is a one-cycle pulse.
  assign in_ready    = (state_q == PBM_SETUP) && !dir_q && in_valid;
  assign out_valid   = (state_q == PBM_OUTPUT);
  assign out_data    = rdata_q;

endmodule
